// File: rtl/dbus_wb_master.sv
// Bridges the CPU data-memory port onto Wishbone: one single-beat transfer at a
// time, with the CPU stalled until the slave acks or the wait budget runs out.
module dbus_wb_master #(
  parameter logic [15:0] TIMEOUT  = 16'd255,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic        flush_i,
  output logic        cpu_stall_o,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_last;
  logic        w_accept;

  // A zero budget behaves like a budget of one wait cycle.
  assign w_cnt_last  = (TIMEOUT == 16'd0) ? 16'd0 : (TIMEOUT - 16'd1);
  assign w_accept    = (r_state == S_IDLE) && cpu_req_i && !flush_i;
  assign cpu_stall_o = w_accept || (r_state == S_BUS);

  // Transfer sequencer; cpu_err_o doubles as the timeout flag held through DONE.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= 16'd0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= 32'd0;
      wb_dat_o    <= 32'd0;
      wb_sel_o    <= 4'd0;
      cpu_rdata_o <= 32'd0;
      cpu_err_o   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          cpu_err_o <= 1'b0;
          if (w_accept) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= cpu_we_i;
            wb_adr_o <= cpu_addr_i;
            wb_dat_o <= cpu_wdata_i;
            wb_sel_o <= cpu_sel_i;
            r_cnt    <= 16'd0;
            r_state  <= S_BUS;
          end else begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
          end
        end
        S_BUS: begin
          // flush_i is deliberately ignored here: a started store must land.
          if (wb_ack_i) begin
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            cpu_rdata_o <= wb_we_o ? 32'd0 : wb_dat_i;
            r_state     <= S_DONE;
          end else if (r_cnt == w_cnt_last) begin
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            cpu_rdata_o <= ERR_DATA;
            cpu_err_o   <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_DONE: begin
          cpu_err_o <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          wb_cyc_o  <= 1'b0;
          wb_stb_o  <= 1'b0;
          cpu_err_o <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_wb_master.sv
// Randomized bench for dbus_wb_master: a word-array slave with programmable
// wait states, checked against a transfer-level model of latency and data.
module tb_dbus_wb_master;

  localparam logic [15:0] TO   = 16'd16;
  localparam logic [31:0] ERR  = 32'hDEAD_BEEF;
  localparam logic [31:0] BASE = 32'hBFAF_F000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cpu_req_i = 1'b0;
  logic        cpu_we_i = 1'b0;
  logic [31:0] cpu_addr_i = 32'd0;
  logic [31:0] cpu_wdata_i = 32'd0;
  logic [3:0]  cpu_sel_i = 4'd0;
  logic        flush_i = 1'b0;
  logic        cpu_stall_o, cpu_err_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic [31:0] cpu_rdata_o, wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] ref_mem [16];
  logic [31:0] slv_mem [16];
  int          slv_wait = 0;
  int          slv_wcnt;
  logic        slv_ack;

  dbus_wb_master #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_sel_i(cpu_sel_i), .flush_i(flush_i),
    .cpu_stall_o(cpu_stall_o), .cpu_rdata_o(cpu_rdata_o), .cpu_err_o(cpu_err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  // Slave acks combinationally once slv_wait wait cycles have elapsed.
  assign slv_ack  = wb_cyc_o && wb_stb_o && (slv_wcnt == slv_wait);
  assign wb_ack_i = slv_ack;
  assign wb_dat_i = slv_mem[wb_adr_o[5:2]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) slv_wcnt <= 0;
    else if (wb_cyc_o && wb_stb_o && !slv_ack) slv_wcnt <= slv_wcnt + 1;
    else slv_wcnt <= 0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) slv_mem[i] <= ref_mem[i];
    end else if (slv_ack && wb_we_o) begin
      for (int b = 0; b < 4; b++)
        if (wb_sel_o[b]) slv_mem[wb_adr_o[5:2]][8*b +: 8] <= wb_dat_o[8*b +: 8];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cpu_req_i = 1'b0;
      flush_i   = 1'b0;
      #1;
      vectors++;
      if ({cpu_stall_o, wb_cyc_o, cpu_err_o} !== 3'b000) begin
        miscompares++;
        $display("FAIL idle: stall/cyc/err=%b required 000", {cpu_stall_o, wb_cyc_o, cpu_err_o});
      end
    end
  endtask

  // Issue one transfer and check it against the transfer-level model.
  task automatic run_xfer(input logic we, input logic [3:0] idx, input logic [31:0] wdata,
                          input logic [3:0] sel, input int wait_c, input logic flush_bus,
                          input string tag);
    logic [31:0] addr, exp_rdata, mask;
    logic        timeout;
    int          exp_stall, n_stall, n_cyc;
    bit          done;
    addr      = BASE | {26'd0, idx, 2'b00};
    timeout   = (wait_c >= int'(TO));
    exp_stall = timeout ? int'(TO) + 1 : wait_c + 2;
    if (timeout) exp_rdata = ERR;
    else if (we) exp_rdata = 32'd0;
    else exp_rdata = ref_mem[idx];

    @(negedge clk);
    slv_wait = wait_c;
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr;
    cpu_wdata_i = wdata; cpu_sel_i = sel; flush_i = 1'b0;
    n_stall = 0; n_cyc = 0; done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      #1;
      if (cpu_stall_o) begin
        n_stall++;
        if (wb_cyc_o) begin
          n_cyc++;
          vectors++;
          if ({wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o} !== {1'b1, we, addr, wdata, sel}) begin
            miscompares++;
            $display("FAIL %s bus_hold: stb/we/adr/dat/sel=%b/%b/%h/%h/%h required 1/%b/%h/%h/%h",
                     tag, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, we, addr, wdata, sel);
          end
        end
        vectors++;
        if (cpu_err_o !== 1'b0) begin
          miscompares++;
          $display("FAIL %s err_early: cpu_err_o=%b required 0", tag, cpu_err_o);
        end
        @(negedge clk);
        flush_i = flush_bus;
      end else begin
        done = 1'b1;
      end
    end
    vectors++;
    if (!done || n_stall != exp_stall || n_cyc != exp_stall - 1) begin
      miscompares++;
      $display("FAIL %s latency: done=%0d stall=%0d cyc=%0d required done=1 stall=%0d cyc=%0d",
               tag, done, n_stall, n_cyc, exp_stall, exp_stall - 1);
    end
    vectors++;
    if ({cpu_rdata_o, cpu_err_o, wb_cyc_o, wb_stb_o} !== {exp_rdata, timeout, 2'b00}) begin
      miscompares++;
      $display("FAIL %s done: rdata=%h err=%b cyc=%b stb=%b required rdata=%h err=%b cyc=0 stb=0",
               tag, cpu_rdata_o, cpu_err_o, wb_cyc_o, wb_stb_o, exp_rdata, timeout);
    end
    flush_i = 1'b0;
    if (we && !timeout) begin
      mask = 32'd0;
      for (int b = 0; b < 4; b++) if (sel[b]) mask = mask | (32'hFF << (8 * b));
      ref_mem[idx] = (ref_mem[idx] & ~mask) | (wdata & mask);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, cpu_rdata_o, cpu_err_o, cpu_stall_o} !== 105'd0) begin
      miscompares++;
      $display("FAIL reset_state: cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h rdata=%h err=%b stall=%b required all 0",
               wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, cpu_rdata_o, cpu_err_o, cpu_stall_o);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_load();
    run_xfer(1'b0, 4'd8, 32'h0, 4'hF, 0, 1'b0, "load_5a");
    vectors++;
    if (cpu_rdata_o !== 32'h0000_005A) begin
      miscompares++;
      $display("FAIL load_5a value: rdata=%h required 0000005a", cpu_rdata_o);
    end
    idle(1);
  endtask

  task automatic test_store_readback();
    run_xfer(1'b1, 4'd0, 32'h0000_1234, 4'hF, 0, 1'b0, "store_led");
    idle(1);
    run_xfer(1'b0, 4'd0, 32'h0, 4'hF, 1, 1'b0, "readback_led");
    vectors++;
    if (cpu_rdata_o !== 32'h0000_1234) begin
      miscompares++;
      $display("FAIL readback_led value: rdata=%h required 00001234", cpu_rdata_o);
    end
    idle(1);
  endtask

  task automatic test_timeout();
    run_xfer(1'b0, 4'd3, $urandom, 4'hF, 1000, 1'b0, "timeout");
    idle(2);
  endtask

  task automatic test_wait_states();
    run_xfer(1'b0, 4'd5, $urandom, 4'hF, 3, 1'b0, "wait3");
    idle(1);
  endtask

  task automatic test_flush();
    @(negedge clk);
    cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = BASE; flush_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if ({cpu_stall_o, wb_cyc_o} !== 2'b00) begin
        miscompares++;
        $display("FAIL flush_idle: stall/cyc=%b required 00", {cpu_stall_o, wb_cyc_o});
      end
      @(negedge clk);
    end
    run_xfer(1'b1, 4'd6, $urandom, 4'b0101, 2, 1'b1, "flush_in_bus");
    idle(1);
    run_xfer(1'b0, 4'd6, $urandom, 4'hF, 0, 1'b0, "flush_readback");
    idle(1);
  endtask

  task automatic test_reset_mid_bus();
    @(negedge clk);
    slv_wait = 50;
    cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = BASE | 32'h8;
    cpu_wdata_i = 32'hCAFE_F00D; cpu_sel_i = 4'hF; flush_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (wb_cyc_o !== 1'b1) begin
      miscompares++;
      $display("FAIL midbus_active: cyc=%b required 1", wb_cyc_o);
    end
    rst_n = 1'b0;
    cpu_req_i = 1'b0;
    #1;
    vectors++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, cpu_rdata_o, cpu_err_o, cpu_stall_o} !== 105'd0) begin
      miscompares++;
      $display("FAIL midbus_reset: cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h rdata=%h err=%b stall=%b required all 0",
               wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, cpu_rdata_o, cpu_err_o, cpu_stall_o);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    run_xfer(1'b0, 4'd2, $urandom, 4'hF, 1, 1'b0, "after_reset_load");
    idle(1);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      int w;
      w = int'($urandom % 8);
      w = (w == 7) ? 20 : (w % 5);
      run_xfer(1'($urandom % 2), 4'($urandom % 16), $urandom, 4'($urandom_range(1, 15)),
               w, 1'($urandom % 2), "random");
      if ($urandom % 2 == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
    ref_mem[8] = 32'h0000_005A;
    test_reset();
    test_load();
    test_store_readback();
    test_timeout();
    test_wait_states();
    test_flush();
    test_reset_mid_bus();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
